// File: rtl/word_unpacker.sv
// word_unpacker: registers a packet of NUM_WORDS words and emits them one per
// transfer, most- or least-significant word first as chosen per packet.
module word_unpacker #(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned NUM_WORDS = 2,
  parameter int unsigned IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0] in_data,
  input  logic                        msw_first,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_last,
  output logic                        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] IDX_FIRST_MSW = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_LSW  = IDX_W'(NUM_WORDS - 1);

  state_t                        state_q, state_d;
  logic [WORD_W*NUM_WORDS-1:0]   pkt_q, pkt_d;
  logic                          msw_q, msw_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [WORD_W-1:0]             data_q, data_d;
  logic                          last_q, last_d;

  logic [WORD_W-1:0]             words [NUM_WORDS];
  logic [IDX_W-1:0]              idx_step;
  logic                          accept;
  logic                          xfer;

  assign out_valid = (state_q == SEND);
  assign busy      = out_valid;
  assign out_data  = data_q;
  assign out_index = idx_q;
  assign out_last  = last_q;
  assign in_ready  = (state_q == IDLE) || (last_q && out_ready);

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  // Split the held packet into addressable words.
  always_comb begin
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      words[k] = pkt_q[k*WORD_W +: WORD_W];
    end
  end

  // Next word position in the direction chosen for the held packet.
  always_comb begin
    idx_step = msw_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
  end

  // Next-state logic: a new packet takes precedence over stepping, which lets
  // the last word of one packet and the load of the next share a cycle.
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    msw_d   = msw_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    if (accept) begin
      state_d = SEND;
      pkt_d   = in_data;
      msw_d   = msw_first;
      last_d  = 1'b0;
      if (msw_first) begin
        idx_d  = IDX_FIRST_MSW;
        data_d = in_data[(NUM_WORDS-1)*WORD_W +: WORD_W];
      end else begin
        idx_d  = '0;
        data_d = in_data[WORD_W-1:0];
      end
    end else if (xfer) begin
      if (last_q) begin
        state_d = IDLE;
        last_d  = 1'b0;
      end else begin
        idx_d  = idx_step;
        data_d = words[idx_step];
        last_d = msw_q ? (idx_step == '0) : (idx_step == IDX_LAST_LSW);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      msw_q   <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      msw_q   <= msw_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule
